// File: rtl/mem_access_unit.sv
// Data-memory access sequencer: runs one load/store per core request over a
// req/gnt + rvalid memory handshake, stalls the core while busy, holds the last load word.
module mem_access_unit #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              stall,
  output logic [DATA_W-1:0] load_data,
  output logic              done,
  output logic              err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rvalid,
  output logic [1:0]        dbg_state
);

  // Memory handshake: mem_req/mem_we/mem_addr/mem_wdata are held stable from the
  // first REQ cycle until the cycle mem_gnt is seen high; read data is taken only
  // in the first RESP cycle with mem_rvalid high, never while still requesting.

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t            state_q, state_d;
  logic [7:0]        cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] load_q;
  logic              we_q;
  logic              err_q;

  logic req_any;
  logic req_bad;
  logic accept;
  logic busy;
  logic timeout_hit;

  assign req_any = mem_read | mem_write;
  assign req_bad = req_any & ((addr[1:0] != 2'b00) | (mem_read & mem_write));
  assign accept  = (state_q == S_IDLE) & req_any & ~req_bad;
  assign busy    = (state_q == S_REQ) | (state_q == S_RESP);

  always_comb begin
    state_d     = state_q;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt) begin
          state_d = we_q ? S_DONE : S_RESP;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid) begin
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          state_d     = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      load_q  <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= ((state_q == S_IDLE) & req_bad) | timeout_hit;
      if (accept) begin
        addr_q  <= {addr[ADDR_W-1:2], 2'b00};
        wdata_q <= wdata;
        we_q    <= mem_write;
        cnt_q   <= 8'd0;
      end else if (busy) begin
        cnt_q <= cnt_q + 8'd1;
      end
      if ((state_q == S_RESP) & mem_rvalid) begin
        load_q <= mem_rdata;
      end
    end
  end

  // The accepting cycle stalls combinationally; gated so reset never shows a stall.
  assign stall     = rst & (accept | busy);
  assign mem_req   = (state_q == S_REQ);
  assign done      = (state_q == S_DONE);
  assign err       = err_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign load_data = load_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: per-cycle protocol checks in the driver, completion
// events checked by a monitor against a queue of expected {event, load_data}.
module tb_mem_access_unit;

  localparam int TMO = 8;

  logic        clk;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        stall;
  logic [31:0] load_data;
  logic        done;
  logic        err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic [1:0]  dbg_state;

  int checks;
  int errors;

  // {event code, expected load_data}; event code is {done, err}
  logic [33:0] exp_q[$];
  logic [31:0] model_load;

  mem_access_unit #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .addr      (addr),
    .wdata     (wdata),
    .stall     (stall),
    .load_data (load_data),
    .done      (done),
    .err       (err),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_gnt   (mem_gnt),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    addr       = '0;
    wdata      = '0;
    mem_gnt    = 1'b0;
    mem_rdata  = '0;
    mem_rvalid = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [33:0] e;
    if (rst && (done || err)) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_event: done=%0b err=%0b with nothing expected at %0t",
                 done, err, $time);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", {62'd0, done, err}, {62'd0, e[33:32]});
        check("event_load_data", {32'd0, load_data}, {32'd0, e[31:0]});
      end
    end
  end

  // ---------------- driver ----------------
  // One core request plus the memory's reaction: gnt arrives after g idle REQ cycles,
  // rvalid r cycles after entering RESP. Outcome derived from cycle arithmetic.
  task automatic run_txn(input logic rd, input logic wr, input logic [31:0] a,
                         input logic [31:0] wd, input int g, input int r,
                         input logic [31:0] rdata);
    bit valid;
    bit completes;
    int k;
    int endc;
    int req_last;
    logic [31:0] load_before;
    valid = (rd || wr) && !(rd && wr) && (a[1:0] == 2'b00);
    if (valid) begin
      k         = wr ? g + 1 : g + 2 + r;
      completes = (k <= TMO);
      if (!completes) k = TMO;
      endc      = k + 1;
    end else begin
      k         = 0;
      completes = 1'b0;
      endc      = 1;
    end
    req_last    = (g + 1 < k) ? g + 1 : k;
    load_before = model_load;
    if (valid && completes && rd) begin
      exp_q.push_back({2'b10, rdata});
      model_load = rdata;
    end else if (valid && completes) begin
      exp_q.push_back({2'b10, model_load});
    end else begin
      exp_q.push_back({2'b01, model_load});
    end

    for (int c = 0; c <= endc; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) begin
        mem_read  = rd;
        mem_write = wr;
        addr      = a;
        wdata     = wd;
      end else if (valid && c <= k) begin
        mem_read  = 1'($urandom_range(0, 1));
        mem_write = 1'($urandom_range(0, 1));
        addr      = $urandom;
        wdata     = $urandom;
      end else begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
      mem_gnt    = valid && c >= 1 && c <= k && c == g + 1;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      if (valid && rd && c >= 1 && c <= k) begin
        if (c <= g + 1) begin
          mem_rvalid = 1'($urandom_range(0, 1));
        end else if (c == g + 2 + r) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rdata;
        end
      end
      @(negedge clk);
      if (c == 0) check("load_hold", {32'd0, load_data}, {32'd0, load_before});
      check("stall", {63'd0, stall}, {63'd0, (valid && c <= k)});
      check("mem_req", {63'd0, mem_req}, {63'd0, (valid && c >= 1 && c <= req_last)});
      if (valid && c >= 1 && c <= req_last) begin
        check("mem_addr", {32'd0, mem_addr}, {32'd0, a});
        check("mem_we", {63'd0, mem_we}, {63'd0, wr});
        check("mem_wdata", {32'd0, mem_wdata}, {32'd0, wd});
      end
      check("done", {63'd0, done}, {63'd0, (valid && completes && c == k + 1)});
      check("err", {63'd0, err},
            {63'd0, ((!valid && c == 1) || (valid && !completes && c == k + 1))});
    end
    idle_inputs();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int kind;
    int g;
    int r;
    logic [31:0] a;
    checks     = 0;
    errors     = 0;
    model_load = '0;
    rst        = 1'b0;
    idle_inputs();

    // Reset held two cycles while a load is requested: everything stays quiet.
    mem_read = 1'b1;
    addr     = 32'h10;
    repeat (2) begin
      @(negedge clk);
      check("rst_stall", {63'd0, stall}, 64'd0);
      check("rst_mem_req", {63'd0, mem_req}, 64'd0);
      check("rst_done_err", {62'd0, done, err}, 64'd0);
      check("rst_load_data", {32'd0, load_data}, 64'd0);
      check("rst_mem_bus", {31'd0, mem_we, mem_addr}, 64'd0);
      check("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    idle_inputs();

    // Directed cases.
    run_txn(1'b1, 1'b0, 32'h10, 32'h0, 0, 0, 32'hDEADBEEF);
    run_txn(1'b0, 1'b1, 32'h20, 32'h1234, 3, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h13, 32'h0, 0, 0, 32'h0);
    run_txn(1'b1, 1'b1, 32'h24, 32'h5, 0, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h30, 32'h0, 0, 100, 32'hAAAA5555);
    run_txn(1'b0, 1'b1, 32'h34, 32'h77, 20, 0, 32'h0);
    run_txn(1'b1, 1'b0, 32'h38, 32'h0, 3, 3, 32'hCAFEF00D);
    run_txn(1'b0, 1'b1, 32'h3C, 32'h99, 7, 0, 32'h0);

    // Reset while waiting for read data: access abandoned, late rvalid ignored.
    @(posedge clk); #1;
    mem_read = 1'b1;
    addr     = 32'h40;
    @(posedge clk); #1;
    mem_read = 1'b0;
    mem_gnt  = 1'b1;
    @(negedge clk);
    check("mrst_req_cycle", {63'd0, mem_req}, 64'd1);
    @(posedge clk); #1;
    mem_gnt = 1'b0;
    rst     = 1'b0;
    @(posedge clk); #1;
    rst        = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h55;
    @(negedge clk);
    check("mrst_state", {62'd0, dbg_state}, 64'd0);
    check("mrst_mem_req", {63'd0, mem_req}, 64'd0);
    check("mrst_stall", {63'd0, stall}, 64'd0);
    check("mrst_done_err", {62'd0, done, err}, 64'd0);
    @(posedge clk); #1;
    mem_rvalid = 1'b0;
    @(negedge clk);
    check("mrst_no_done", {62'd0, done, err}, 64'd0);
    check("mrst_load_data", {32'd0, load_data}, 64'd0);
    model_load = '0;
    idle_inputs();

    // Randomized traffic.
    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 9);
      g    = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      r    = ($urandom_range(0, 7) == 0) ? $urandom_range(5, 10) : $urandom_range(0, 3);
      a    = $urandom & 32'hFFFF_FFFC;
      case (kind)
        0:       run_txn(1'b1, 1'b0, a | 32'($urandom_range(1, 3)), $urandom, g, r, $urandom);
        1:       run_txn(1'b1, 1'b1, a, $urandom, g, r, $urandom);
        2, 3, 4: run_txn(1'b0, 1'b1, a, $urandom, g, r, $urandom);
        default: run_txn(1'b1, 1'b0, a, $urandom, g, r, $urandom);
      endcase
    end

    repeat (3) @(negedge clk);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
